// File: rtl/pong_pkg.sv
// Shared constants and types for the paddle pushbutton conditioner.
package pong_pkg;

  localparam int CLK_HZ              = 48_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = 480_000;     // 10 ms
  localparam int REPEAT_DELAY_DEF    = 24_000_000;  // 500 ms
  localparam int REPEAT_PERIOD_DEF   = 2_400_000;   // 50 ms

  typedef enum logic [1:0] {
    LO      = 2'd0,
    WAIT_HI = 2'd1,
    HI      = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_e;

  localparam int LEFT_UP  = 0;
  localparam int LEFT_DN  = 1;
  localparam int RIGHT_UP = 2;
  localparam int RIGHT_DN = 3;

endpackage

// File: rtl/puls_debounce.sv
// One button: 2-FF synchroniser, counter debouncer FSM and press-edge pulse.
// level_nxt/press_nxt expose the next-cycle values so the parent can register steps in the same cycle.
module puls_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic level_nxt,
  output logic press_nxt
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DONE = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, press_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LO: if (s2_q) begin
        state_d = WAIT_HI;
        cnt_d   = '0;
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = LO;
          cnt_d   = '0;
        end else if (cnt_q == DONE) begin
          state_d = HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: if (!s2_q) begin
        state_d = WAIT_LO;
        cnt_d   = '0;
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = HI;
          cnt_d   = '0;
        end else if (cnt_q == DONE) begin
          state_d = LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_nxt = (state_d == HI) || (state_d == WAIT_LO);
  assign press_nxt = (state_q == WAIT_HI) && (state_d == HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_nxt;
      press_q <= press_nxt;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/puls_conditioner.sv
// Paddle pushbutton conditioner: per-button debounce, optional auto-repeat, pair arbitration.
// Define PULS_AUTOREPEAT_EN to build the auto-repeat counters; otherwise one step per press.
module puls_conditioner
  import pong_pkg::*;
#(
  parameter int N_PULS          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PULS-1:0] puls_raw,
  output logic [N_PULS-1:0] puls_level,
  output logic [N_PULS-1:0] puls_press,
  output logic [N_PULS-1:0] puls_step
);

  if (N_PULS % 2 != 0) begin : g_chk_pairs
    $error("N_PULS must be even");
  end
  if (REPEAT_PERIOD < 2 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_chk_repeat
    $error("need REPEAT_PERIOD >= 2 and REPEAT_DELAY >= REPEAT_PERIOD");
  end

  logic [N_PULS-1:0] level_nxt, press_nxt, fire, step_d, step_q;

  for (genvar g = 0; g < N_PULS; g++) begin : g_deb
    puls_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk       (clk),
      .reset     (reset),
      .raw       (puls_raw[g]),
      .level     (puls_level[g]),
      .press     (puls_press[g]),
      .level_nxt (level_nxt[g]),
      .press_nxt (press_nxt[g])
    );
  end

`ifdef PULS_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RMAX  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RLOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  // Counter tops out at REPEAT_DELAY and reloads so the next hit is one period later.
  for (genvar g = 0; g < N_PULS; g++) begin : g_rep
    logic [RW-1:0] rep_q, rep_d;

    always_comb begin
      rep_d = rep_q;
      if (press_nxt[g] || !level_nxt[g]) rep_d = '0;
      else if (rep_q == RMAX)            rep_d = RLOAD;
      else                               rep_d = rep_q + 1'b1;
    end

    assign fire[g] = press_nxt[g] | (level_nxt[g] & (rep_d == RMAX));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) rep_q <= '0;
      else       rep_q <= rep_d;
    end
  end
`else
  assign fire = press_nxt;
`endif

  // A paddle with both directions held gets no steps; counters keep running underneath.
  for (genvar g = 0; g < N_PULS; g++) begin : g_arb
    localparam int P = g ^ 1;
    assign step_d[g] = fire[g] & ~(level_nxt[g] & level_nxt[P]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= '0;
    else       step_q <= step_d;
  end

  assign puls_step = step_q;

endmodule

// File: tb/tb_puls_conditioner.sv
// Scoreboard bench for puls_conditioner (DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10).
module tb_puls_conditioner;

  localparam int D  = 8;
  localparam int RD = 40;
  localparam int RP = 10;
  localparam int LAT = D + 3;  // drive cycle -> level/press cycle

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] puls_raw;
  logic [3:0] puls_level, puls_press, puls_step;

  puls_conditioner #(
    .N_PULS(4), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .puls_raw   (puls_raw),
    .puls_level (puls_level),
    .puls_press (puls_press),
    .puls_step  (puls_step)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] step;
    logic [3:0] level;
  } ev_t;

  ev_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] s, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.step = s; e.level = l;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle with a press or step must match the next scoreboard entry.
  always @(negedge clk) begin : mon
    ev_t e;
    if ((puls_press | puls_step) != 4'b0000) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d press=%b step=%b level=%b",
                 cyc, puls_press, puls_step, puls_level);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.press !== puls_press || e.step !== puls_step || e.level !== puls_level) begin
          errors++;
          $display("FAIL event got cyc=%0d press=%b step=%b level=%b want cyc=%0d press=%b step=%b level=%b",
                   cyc, puls_press, puls_step, puls_level, e.cyc, e.press, e.step, e.level);
        end
      end
    end
  end

  initial begin
    int c;
    reset    = 1'b1;
    puls_raw = 4'b0000;
    tick(3);
    chk("reset_level", puls_level, 4'b0000);
    chk("reset_press", puls_press, 4'b0000);
    chk("reset_step",  puls_step,  4'b0000);
    reset = 1'b0;
    tick(3);

    // 1: single press, released before any repeat
    c = cyc;
    puls_raw[0] = 1'b1;
    push(c + LAT, 4'b0001, 4'b0001, 4'b0001);
    tick(15);
    chk("t1_level_held", puls_level, 4'b0001);
    tick(5);
    puls_raw[0] = 1'b0;
    tick(25);
    chk("t1_level_release", puls_level, 4'b0000);

    // 2: short glitch is rejected
    puls_raw[2] = 1'b1;
    tick(5);
    puls_raw[2] = 1'b0;
    tick(3);
    chk("t2_glitch_level_mid", puls_level, 4'b0000);
    tick(20);
    chk("t2_glitch_level", puls_level, 4'b0000);

    // 3: hold for 100 cycles of level, release so level falls exactly at +100
    c = cyc;
    puls_raw[1] = 1'b1;
    push(c + LAT, 4'b0010, 4'b0010, 4'b0010);
`ifdef PULS_AUTOREPEAT_EN
    for (int j = RD; j <= 90; j += RP) push(c + LAT + j, 4'b0000, 4'b0010, 4'b0010);
`endif
    tick(50);
    chk("t3_level_held", puls_level, 4'b0010);
    tick(50);
    puls_raw[1] = 1'b0;
    tick(25);
    chk("t3_level_release", puls_level, 4'b0000);

    // 4: both buttons of the left pair held; release one, the other resumes
    c = cyc;
    puls_raw[1:0] = 2'b11;
    push(c + LAT, 4'b0011, 4'b0000, 4'b0011);
`ifdef PULS_AUTOREPEAT_EN
    push(c + LAT + 60, 4'b0000, 4'b0001, 4'b0001);
    push(c + LAT + 70, 4'b0000, 4'b0001, 4'b0001);
`endif
    tick(55);
    chk("t4_both_level", puls_level, 4'b0011);
    puls_raw[1] = 1'b0;
    tick(21);
    chk("t4_one_level", puls_level, 4'b0001);
    puls_raw[0] = 1'b0;
    tick(25);
    chk("t4_level_release", puls_level, 4'b0000);

    // 5: bouncing input then steady high
    puls_raw[3] = 1'b1; tick(3);
    puls_raw[3] = 1'b0; tick(3);
    puls_raw[3] = 1'b1; tick(3);
    puls_raw[3] = 1'b0; tick(3);
    chk("t5_bounce_level", puls_level, 4'b0000);
    c = cyc;
    puls_raw[3] = 1'b1;
    push(c + LAT, 4'b1000, 4'b1000, 4'b1000);
    tick(20);
    puls_raw[3] = 1'b0;
    tick(25);
    chk("t5_level_release", puls_level, 4'b0000);

    // 6: reset mid-repeat, release with raw still high
    c = cyc;
    puls_raw[2] = 1'b1;
    push(c + LAT, 4'b0100, 4'b0100, 4'b0100);
    tick(LAT + 25);
    chk("t6_level_before_reset", puls_level, 4'b0100);
    reset = 1'b1;
    #1;
    chk("t6_reset_level", puls_level, 4'b0000);
    chk("t6_reset_press", puls_press, 4'b0000);
    chk("t6_reset_step",  puls_step,  4'b0000);
    tick(3);
    c = cyc;
    reset = 1'b0;
    push(c + LAT, 4'b0100, 4'b0100, 4'b0100);
    tick(LAT - 1);
    chk("t6_no_early_level", puls_level, 4'b0000);
    tick(2);
    chk("t6_level_after", puls_level, 4'b0100);
    tick(18);
    puls_raw[2] = 1'b0;
    tick(25);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d pending want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
